// File: rtl/sram_like_arbiter.sv
// Merges NUM_CH sram-like masters onto one sram-like slave port.
// Accepted request IDs sit in an in-order FIFO so each data_ok returns to its issuer.
module sram_like_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 4,
  parameter int ARB_MODE    = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CH-1:0]                 ch_req,
  input  logic [NUM_CH-1:0]                 ch_wr,
  input  logic [2*NUM_CH-1:0]               ch_size,
  input  logic [ADDR_W*NUM_CH-1:0]          ch_addr,
  input  logic [DATA_W*NUM_CH-1:0]          ch_wdata,
  input  logic [DATA_W/8*NUM_CH-1:0]        ch_wstrb,
  output logic [NUM_CH-1:0]                 ch_addr_ok,
  output logic [NUM_CH-1:0]                 ch_data_ok,
  output logic [DATA_W-1:0]                 ch_rdata,
  output logic                              m_req,
  output logic                              m_wr,
  output logic [1:0]                        m_size,
  output logic [ADDR_W-1:0]                 m_addr,
  output logic [DATA_W-1:0]                 m_wdata,
  output logic [DATA_W/8-1:0]               m_wstrb,
  input  logic                              m_addr_ok,
  input  logic                              m_data_ok,
  input  logic [DATA_W-1:0]                 m_rdata,
  output logic [$clog2(OUTSTANDING+1)-1:0]  outstanding,
  output logic                              err_unexp
);

  // state | meaning
  // IDLE  | no lock; grant comes from the arbiter when the FIFO has room
  // HOLD  | slave stalled a request; grant stays on lock_ch until accepted

  localparam int STRB_W = DATA_W / 8;
  localparam int ID_W   = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W  = $clog2(OUTSTANDING + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_nx;
  logic [ID_W-1:0]   lock_ch, lock_nx;
  logic [ID_W-1:0]   rr_ptr, rr_nx;
  logic [ID_W-1:0]   id_fifo [OUTSTANDING];
  logic [PTR_W-1:0]  wptr, rptr;
  logic [CNT_W-1:0]  count;
  logic              err_q;

  logic              arb_valid;
  logic [ID_W-1:0]   arb_id;
  logic              grant_valid;
  logic [ID_W-1:0]   grant;
  logic              accept, pop, unexp;
  logic [ID_W-1:0]   head_id;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Two-pass search: first requester at or above base, else lowest requester.
  always_comb begin
    int   base;
    logic hi_found, lo_found;
    logic [ID_W-1:0] hi_id, lo_id;
    base     = (ARB_MODE == 1) ? int'(rr_ptr) : 0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_req[i] && !hi_found && i >= base) begin
        hi_found = 1'b1;
        hi_id    = ID_W'(i);
      end
      if (ch_req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
      end
    end
    arb_valid = hi_found | lo_found;
    arb_id    = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    if (!reset) begin
      if (state == HOLD) begin
        grant_valid = 1'b1;
        grant       = lock_ch;
      end else begin
        grant_valid = arb_valid && (count < CNT_W'(OUTSTANDING));
        grant       = arb_id;
      end
    end
  end

  assign head_id = id_fifo[rptr];
  assign accept  = grant_valid && m_addr_ok;
  assign pop     = !reset && m_data_ok && (count != '0);
  assign unexp   = !reset && m_data_ok && (count == '0);

  always_comb begin
    m_req      = grant_valid;
    m_wr       = 1'b0;
    m_size     = '0;
    m_addr     = '0;
    m_wdata    = '0;
    m_wstrb    = '0;
    ch_addr_ok = '0;
    ch_data_ok = '0;
    ch_rdata   = pop ? m_rdata : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_valid && grant == ID_W'(i)) begin
        m_wr    = ch_wr[i];
        m_size  = ch_size[2*i +: 2];
        m_addr  = ch_addr[ADDR_W*i +: ADDR_W];
        m_wdata = ch_wdata[DATA_W*i +: DATA_W];
        m_wstrb = ch_wstrb[STRB_W*i +: STRB_W];
      end
      ch_addr_ok[i] = accept && (grant == ID_W'(i));
      ch_data_ok[i] = pop && (head_id == ID_W'(i));
    end
  end

  always_comb begin
    state_nx = state;
    lock_nx  = lock_ch;
    rr_nx    = rr_ptr;
    if (grant_valid && !m_addr_ok) begin
      state_nx = HOLD;
      lock_nx  = grant;
    end else begin
      state_nx = IDLE;
    end
    if (accept) begin
      rr_nx = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lock_ch <= '0;
      rr_ptr  <= '0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      lock_ch <= lock_nx;
      rr_ptr  <= rr_nx;
      if (accept) wptr <= ptr_inc(wptr);
      if (pop)    rptr <= ptr_inc(rptr);
      if (accept && !pop)      count <= count + 1'b1;
      else if (!accept && pop) count <= count - 1'b1;
      if (unexp) err_q <= 1'b1;
    end
  end

  // ID storage needs no reset; only entries between rptr and wptr are ever read.
  always_ff @(posedge clk) begin
    if (accept) id_fifo[wptr] <= grant;
  end

  assign outstanding = reset ? '0 : count;
  assign err_unexp   = !reset && err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: fixed-priority and round-robin instances share stimulus,
// checked by constant vectors, hand sequences and a queue-based reference model.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  ch_req, ch_wr;
  logic [3:0]  ch_size;
  logic [63:0] ch_addr, ch_wdata;
  logic [7:0]  ch_wstrb;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;

  logic [1:0]  f_aok, f_dok, r_aok, r_dok;
  logic [31:0] f_rdata, r_rdata, f_maddr, r_maddr, f_mwdata, r_mwdata;
  logic        f_mreq, r_mreq, f_mwr, r_mwr, f_err, r_err;
  logic [1:0]  f_msize, r_msize;
  logic [3:0]  f_mwstrb, r_mwstrb;
  logic [2:0]  f_out, r_out;

  sram_like_arbiter #(.ARB_MODE(0)) dut_fix (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
    .ch_addr_ok(f_aok), .ch_data_ok(f_dok), .ch_rdata(f_rdata),
    .m_req(f_mreq), .m_wr(f_mwr), .m_size(f_msize), .m_addr(f_maddr),
    .m_wdata(f_mwdata), .m_wstrb(f_mwstrb), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .outstanding(f_out), .err_unexp(f_err));

  sram_like_arbiter #(.ARB_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
    .ch_addr_ok(r_aok), .ch_data_ok(r_dok), .ch_rdata(r_rdata),
    .m_req(r_mreq), .m_wr(r_mwr), .m_size(r_msize), .m_addr(r_maddr),
    .m_wdata(r_mwdata), .m_wstrb(r_mwstrb), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata), .outstanding(r_out), .err_unexp(r_err));

  int checks = 0;
  int errors = 0;

  // Reference model state per instance (0 = fixed, 1 = round-robin).
  int qb [2][8];
  int qn [2];
  int lock [2];
  int rr [2];
  bit merr [2];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      string p;
      logic [1:0] aaok, adok, amsize, eaok, edok;
      logic amreq, amwr, aerr;
      logic [31:0] amaddr, amwdata, ardata;
      logic [3:0] amwstrb;
      logic [2:0] aout;
      int g;
      bit pop;
      p = (k == 0) ? "fix" : "rr";
      if (k == 0) begin
        aaok = f_aok; adok = f_dok; amreq = f_mreq; amwr = f_mwr; amsize = f_msize;
        amaddr = f_maddr; amwdata = f_mwdata; amwstrb = f_mwstrb; ardata = f_rdata;
        aout = f_out; aerr = f_err;
      end else begin
        aaok = r_aok; adok = r_dok; amreq = r_mreq; amwr = r_mwr; amsize = r_msize;
        amaddr = r_maddr; amwdata = r_mwdata; amwstrb = r_mwstrb; ardata = r_rdata;
        aout = r_out; aerr = r_err;
      end
      if (reset) begin
        check({p, " rst m_req"}, amreq, 0);
        check({p, " rst addr_ok"}, aaok, 0);
        check({p, " rst data_ok"}, adok, 0);
        check({p, " rst outstanding"}, aout, 0);
        check({p, " rst err"}, aerr, 0);
        qn[k] = 0; lock[k] = -1; rr[k] = 0; merr[k] = 0;
      end else begin
        g = -1;
        if (lock[k] >= 0) g = lock[k];
        else if (qn[k] < 4) begin
          int start;
          start = (k == 1) ? rr[k] : 0;
          for (int off = 0; off < 2; off++) begin
            int c;
            c = (start + off) % 2;
            if (g < 0 && ch_req[c]) g = c;
          end
        end
        pop  = m_data_ok && (qn[k] > 0);
        eaok = (g >= 0 && m_addr_ok) ? 2'(1 << g) : 2'b00;
        edok = pop ? 2'(1 << qb[k][0]) : 2'b00;
        check({p, " m_req"}, amreq, (g >= 0));
        check({p, " addr_ok"}, aaok, eaok);
        check({p, " data_ok"}, adok, edok);
        check({p, " outstanding"}, aout, qn[k]);
        check({p, " err"}, aerr, merr[k]);
        if (g >= 0) begin
          check({p, " m_addr"}, amaddr, ch_addr[g*32 +: 32]);
          check({p, " m_wdata"}, amwdata, ch_wdata[g*32 +: 32]);
          check({p, " m_wstrb"}, amwstrb, ch_wstrb[g*4 +: 4]);
          check({p, " m_size"}, amsize, ch_size[g*2 +: 2]);
          check({p, " m_wr"}, amwr, ch_wr[g]);
        end else begin
          check({p, " idle m_addr"}, amaddr, 0);
        end
        if (pop) check({p, " rdata"}, ardata, m_rdata);
        if (pop) begin
          for (int i = 0; i < qn[k] - 1; i++) qb[k][i] = qb[k][i+1];
          qn[k]--;
        end else if (m_data_ok) begin
          merr[k] = 1'b1;
        end
        if (g >= 0 && m_addr_ok) begin
          qb[k][qn[k]] = g;
          qn[k]++;
          lock[k] = -1;
          rr[k] = (g + 1) % 2;
        end else if (g >= 0) begin
          lock[k] = g;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ch_req = 2'b11; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    repeat (2) begin
      settle();
      check("reset m_req", f_mreq, 0);
      check("reset outstanding", r_out, 0);
      adv();
    end
    reset = 1'b0; ch_req = 2'b00; m_data_ok = 1'b0; m_addr_ok = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic [1:0]  f_aok, r_aok, f_dok, r_dok;
    int          outst;
    logic        err;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{2'b11, 1, 0, 32'h1000, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0};
    tbl[1]  = '{2'b11, 1, 0, 32'h1001, 2'b01, 2'b10, 2'b00, 2'b00, 1, 0};
    tbl[2]  = '{2'b11, 1, 0, 32'h1002, 2'b01, 2'b01, 2'b00, 2'b00, 2, 0};
    tbl[3]  = '{2'b11, 1, 0, 32'h1003, 2'b01, 2'b10, 2'b00, 2'b00, 3, 0};
    tbl[4]  = '{2'b11, 1, 0, 32'h1004, 2'b00, 2'b00, 2'b00, 2'b00, 4, 0};
    tbl[5]  = '{2'b11, 1, 1, 32'hAAAA, 2'b00, 2'b00, 2'b01, 2'b01, 4, 0};
    tbl[6]  = '{2'b11, 1, 0, 32'h1006, 2'b01, 2'b01, 2'b00, 2'b00, 3, 0};
    tbl[7]  = '{2'b00, 0, 1, 32'h2007, 2'b00, 2'b00, 2'b01, 2'b10, 4, 0};
    tbl[8]  = '{2'b00, 0, 1, 32'h2008, 2'b00, 2'b00, 2'b01, 2'b01, 3, 0};
    tbl[9]  = '{2'b00, 0, 1, 32'h2009, 2'b00, 2'b00, 2'b01, 2'b10, 2, 0};
    tbl[10] = '{2'b00, 0, 1, 32'h200A, 2'b00, 2'b00, 2'b01, 2'b01, 1, 0};
    tbl[11] = '{2'b00, 0, 0, 32'h200B, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0};
    tbl[12] = '{2'b00, 0, 1, 32'h200C, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0};
    tbl[13] = '{2'b00, 0, 0, 32'h200D, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1};

    reset = 1'b1; ch_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    ch_wr = 2'b10; ch_size = {2'd1, 2'd2};
    ch_addr = {32'h0000_0200, 32'h0000_0100};
    ch_wdata = {32'hD1D1_D1D1, 32'hD0D0_D0D0};
    ch_wstrb = {4'h3, 4'hF};
    qn[0] = 0; qn[1] = 0; lock[0] = -1; lock[1] = -1; rr[0] = 0; rr[1] = 0;
    merr[0] = 0; merr[1] = 0;

    do_reset();

    for (int i = 0; i < 14; i++) begin
      ch_req = tbl[i].req; m_addr_ok = tbl[i].aok; m_data_ok = tbl[i].dok;
      m_rdata = tbl[i].rdata;
      settle();
      check($sformatf("vec%0d fix addr_ok", i), f_aok, tbl[i].f_aok);
      check($sformatf("vec%0d rr addr_ok", i), r_aok, tbl[i].r_aok);
      check($sformatf("vec%0d fix data_ok", i), f_dok, tbl[i].f_dok);
      check($sformatf("vec%0d rr data_ok", i), r_dok, tbl[i].r_dok);
      check($sformatf("vec%0d fix outstanding", i), f_out, tbl[i].outst);
      check($sformatf("vec%0d rr outstanding", i), r_out, tbl[i].outst);
      check($sformatf("vec%0d fix err", i), f_err, tbl[i].err);
      if (tbl[i].dok && tbl[i].outst != 0)
        check($sformatf("vec%0d rdata", i), f_rdata, tbl[i].rdata);
      adv();
    end

    // Stalled ch1 request must stay granted while ch0 joins.
    do_reset();
    ch_req = 2'b10; m_addr_ok = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c >= 2) begin
        ch_req = 2'b11;
        ch_addr[31:0] = 32'h0000_0100 + 32'(c);
      end
      settle();
      check($sformatf("hold c%0d fix m_addr", c), f_maddr, 32'h200);
      check($sformatf("hold c%0d rr m_addr", c), r_maddr, 32'h200);
      check($sformatf("hold c%0d fix m_wr", c), f_mwr, 1);
      check($sformatf("hold c%0d fix addr_ok", c), f_aok, 2'b00);
      adv();
    end
    m_addr_ok = 1'b1;
    settle();
    check("hold c4 fix addr_ok", f_aok, 2'b10);
    check("hold c4 rr addr_ok", r_aok, 2'b10);
    adv();
    settle();
    check("hold c5 fix addr_ok", f_aok, 2'b01);
    check("hold c5 rr addr_ok", r_aok, 2'b01);
    adv();

    // Response routing.
    do_reset();
    ch_req = 2'b01; m_addr_ok = 1'b1; settle(); adv();
    ch_req = 2'b10; settle(); adv();
    ch_req = 2'b00; m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hAAAA;
    settle();
    check("resp1 fix data_ok", f_dok, 2'b01);
    check("resp1 rdata", f_rdata, 32'hAAAA);
    check("resp1 rr data_ok", r_dok, 2'b01);
    adv();
    m_rdata = 32'hBBBB;
    settle();
    check("resp2 fix data_ok", f_dok, 2'b10);
    check("resp2 rdata", r_rdata, 32'hBBBB);
    check("resp2 rr data_ok", r_dok, 2'b10);
    adv();
    m_data_ok = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (lock[0] == c || lock[1] == c) begin
          ch_req[c] = 1'b1;
        end else begin
          ch_req[c] = ($urandom_range(0, 2) != 0);
          ch_wr[c] = $urandom_range(0, 1);
          ch_size[c*2 +: 2] = 2'($urandom_range(0, 3));
          ch_addr[c*32 +: 32] = $urandom;
          ch_wdata[c*32 +: 32] = $urandom;
          ch_wstrb[c*4 +: 4] = 4'($urandom_range(0, 15));
        end
      end
      m_addr_ok = ($urandom_range(0, 2) != 0);
      m_data_ok = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      settle();
      adv();
    end

    // Reset in the middle of traffic.
    ch_req = 2'b11; m_addr_ok = 1'b1; m_data_ok = 1'b0;
    settle(); adv();
    settle(); adv();
    reset = 1'b1; m_data_ok = 1'b1;
    settle();
    check("midrst fix outstanding", f_out, 0);
    check("midrst rr data_ok", r_dok, 2'b00);
    adv();
    reset = 1'b0; ch_req = 2'b00; m_data_ok = 1'b0; m_addr_ok = 1'b0;
    settle();
    check("postrst fix outstanding", f_out, 0);
    check("postrst rr outstanding", r_out, 0);
    check("postrst fix err", f_err, 0);
    check("postrst rr err", r_err, 0);
    adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
